ws2812_rx: RTL
==============

Name: ws2812_rx

Overview:
- Single-wire NRZ pixel-stream receiver, the receive end of the GRB serial protocol our LED driver transmits.
- Measures high-pulse widths on the data line to recover bits and assembles 24-bit GRB words, MSB first (G7 first).
- Emits one strobe per pixel with its index, and detects the low "reset/latch" gap as frame end.
- Used for loopback checking of the LED driver and for cascading boards.

Parameters:
- LEDNUM, 25: pixels accepted per frame; pixels beyond this are not emitted.
- TH_GLITCH, 5: high pulses shorter than this many clk cycles are errors.
- TH_THRESH, 30: high width >= TH_THRESH decodes as 1, otherwise 0 (50 MHz: T0H 20, T1H 40).
- TH_MAX, 60: high width above this is an error.
- RESET_CYC, 2500: low time in clk cycles that ends a frame (50 us at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  serial data line, asynchronous to clk.
- grb  out  24  last completed pixel {G,R,B}.
- addr  out  6  pixel index of grb, 0..LEDNUM-1.
- pixel_valid  out  1  one-cycle strobe; grb/addr are valid while it is high.
- frame_done  out  1  one-cycle strobe on detection of the reset gap.
- pixel_count  out  6  number of pixels received in the last frame, saturating at LEDNUM; updated with frame_done.
- frame_err  out  1  one-cycle strobe on any protocol error.
- busy  out  1  high from the first rising edge of a frame until frame_done or error.
- dout  out  1  downstream data; tied 0 unless RX_FORWARD_EN is defined.

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous and active-low. While rst_n=0, all outputs are 0 and the block sits in state WAIT_GAP.
- din passes through a 2-FF synchronizer (reset value 0) to give s_din; a registered copy gives edge detection.
- Width counter: 12 bits, saturating at RESET_CYC.
- Bit counter: 5 bits.
- Pixel counter: 6 bits, saturating at LEDNUM.
- WAIT_GAP: count low cycles; any high clears the count. At RESET_CYC go to IDLE. No strobes are emitted in this state.
- IDLE: on a rising edge of s_din, go to HIGH with count=1, set busy=1, bit counter=0, pixel counter=0.
- HIGH: count++ each cycle s_din=1.
  - Count exceeding TH_MAX while still high: pulse frame_err, clear busy, go to WAIT_GAP.
  - On falling edge with count < TH_GLITCH: same error handling.
  - On a valid falling edge: shift bit (count >= TH_THRESH) into the LSB of the shift register, bit counter +1, go to LOW with count=1.
- 24th bit: when the bit counter reaches 24 and pixel counter < LEDNUM:
  - Next cycle: grb = shift register, addr = pixel counter, pixel_valid=1.
  - Then pixel counter +1 and bit counter wraps to 0.
  - If pixel counter >= LEDNUM, the bit counter still wraps but no strobe is emitted.
- LOW: count++ each cycle s_din=0.
  - Rising edge: go to HIGH with count=1. Low width is otherwise unchecked.
  - Count reaching RESET_CYC: pulse frame_done, load pixel_count, clear busy, go to IDLE.
  - If bit counter != 0 at that point (partial pixel): pulse frame_err in the same cycle as frame_done and discard the partial bits.
- Latency: pixel_valid rises 2 clk after the cycle in which s_din first reads low after the 24th high pulse, which is 4 clk after din falls.
- Simultaneous events: pixel_valid and frame_done are never in the same cycle, because RESET_CYC > 2.
- Reset mid-frame: no pixel_valid is produced for the partial pixel; after release the block waits a full gap before accepting data.
- grb and addr hold their values between strobes.

Optional Feature:
- Macro: RX_FORWARD_EN.
- When defined: once pixel counter >= LEDNUM within a frame, dout = s_din registered one cycle, forwarding remaining pixels to the next board. dout is 0 otherwise and is forced 0 in WAIT_GAP.
- When undefined: dout is constant 0 and no forwarding logic is built.

Test Plan:
- Reset, then din low for 2500 cycles, then 24 bits of 0x5AC3F0 (1 = 40 high/22 low, 0 = 20 high/42 low), then 2600 low -> one pixel_valid with grb=0x5AC3F0, addr=0; frame_done; pixel_count=1; no frame_err.
- 27 pixels with value = index, then gap -> 25 strobes with addr 0..24; pixel_count=25. With RX_FORWARD_EN, dout replicates pixels 25..26 delayed 3 clk from din.
- Data without the initial 2500-cycle low gap after reset -> no strobes until a gap is seen.
- 3-cycle high pulse mid-pixel -> frame_err, busy=0; the next frame after a gap decodes correctly.
- High held 70 cycles -> frame_err when the count passes 60.
- 12 bits, then gap -> frame_done and frame_err in the same cycle, pixel_count=0, no pixel_valid.
- Assert rst_n=0 at bit 10 -> outputs 0 immediately (asynchronous); resume only after a full gap.

Source files
------------

// File: rtl/ws2812_rx_if.sv
// ---------------------------------------------------------------------------
// ws2812_rx_if -- result bundle of the WS2812-style NRZ pixel receiver.
//
// Signals (driven by the receiver through the master modport):
//   grb[23:0]         last completed pixel {G,R,B}
//   addr[5:0]         pixel index belonging to grb
//   pixel_valid       one-cycle strobe, grb/addr valid while high
//   frame_done        one-cycle strobe when the latch gap is seen
//   pixel_count[5:0]  pixels received in the last frame (saturating)
//   frame_err         one-cycle strobe on any protocol error
//   busy              frame in progress
//   dout              downstream (forwarded) data line
// ---------------------------------------------------------------------------
interface ws2812_rx_if;
    logic [23:0] grb;
    logic [5:0]  addr;
    logic        pixel_valid;
    logic        frame_done;
    logic [5:0]  pixel_count;
    logic        frame_err;
    logic        busy;
    logic        dout;

    modport master (
        output grb, addr, pixel_valid, frame_done, pixel_count,
               frame_err, busy, dout
    );

    modport slave (
        input  grb, addr, pixel_valid, frame_done, pixel_count,
               frame_err, busy, dout
    );
endinterface

// File: rtl/ws2812_rx.sv
// ---------------------------------------------------------------------------
// ws2812_rx -- single-wire NRZ GRB pixel-stream receiver.
//
// Measures the width of each high pulse on din to recover bits (long = 1,
// short = 0), assembles 24-bit GRB words MSB first, strobes each pixel with
// its index and detects the long low latch gap as the end of a frame.
//
// Ports:
//   clk    system clock (50 MHz nominal)
//   rst_n  asynchronous active-low reset
//   din    serial data line, asynchronous to clk
//   rx     ws2812_rx_if.master: grb, addr, pixel_valid, frame_done,
//          pixel_count, frame_err, busy, dout
//
// Optional build macro:
//   RX_FORWARD_EN  when defined, pixels beyond LEDNUM are re-emitted on dout
//                  (synchronised din, one extra register); otherwise dout is
//                  tied low and no forwarding logic exists.
// ---------------------------------------------------------------------------
module ws2812_rx #(
    parameter int LEDNUM    = 25,
    parameter int TH_GLITCH = 5,
    parameter int TH_THRESH = 30,
    parameter int TH_MAX    = 60,
    parameter int RESET_CYC = 2500
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    ws2812_rx_if.master   rx
);

    localparam logic [11:0] CNT_GLITCH = 12'(TH_GLITCH);
    localparam logic [11:0] CNT_THRESH = 12'(TH_THRESH);
    localparam logic [11:0] CNT_MAX    = 12'(TH_MAX);
    localparam logic [11:0] CNT_RESET  = 12'(RESET_CYC);
    localparam logic [5:0]  PIX_MAX    = 6'(LEDNUM);
    localparam logic [4:0]  BITS_PIX   = 5'd24;

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } state_t;

    // synchroniser and edge-detect history
    logic        din_meta_q;
    logic        din_sync_q;
    logic        din_prev_q;
    logic        s_din;
    logic        rise_s;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] cnt_inc_s;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  pix_cnt_q, pix_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [23:0] grb_q, grb_d;
    logic [5:0]  addr_q, addr_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        frame_done_q, frame_done_d;
    logic [5:0]  pixel_count_q, pixel_count_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;

    assign s_din  = din_sync_q;
    assign rise_s = din_sync_q & ~din_prev_q;

    // Two-stage synchroniser for din plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_meta_q <= 1'b0;
            din_sync_q <= 1'b0;
            din_prev_q <= 1'b0;
        end else begin
            din_meta_q <= din;
            din_sync_q <= din_meta_q;
            din_prev_q <= din_sync_q;
        end
    end

    // Next-state, pulse-width measurement and output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        shift_d       = shift_q;
        grb_d         = grb_q;
        addr_d        = addr_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        pixel_count_d = pixel_count_q;
        frame_err_d   = 1'b0;
        busy_d        = busy_q;

        // width counter saturates so a long idle line never wraps
        if (cnt_q < CNT_RESET) begin
            cnt_inc_s = cnt_q + 12'd1;
        end else begin
            cnt_inc_s = cnt_q;
        end

        case (state_q)
            WAIT_GAP: begin
                busy_d = 1'b0;
                if (s_din) begin
                    cnt_d = 12'd0;
                end else if (cnt_inc_s == CNT_RESET) begin
                    cnt_d   = 12'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end

            IDLE: begin
                if (rise_s) begin
                    state_d   = HIGH;
                    cnt_d     = 12'd1;
                    busy_d    = 1'b1;
                    bit_cnt_d = 5'd0;
                    pix_cnt_d = 6'd0;
                end else begin
                    cnt_d = 12'd0;
                end
            end

            HIGH: begin
                if (s_din) begin
                    // one more high cycle would exceed the maximum width
                    if (cnt_q >= CNT_MAX) begin
                        frame_err_d = 1'b1;
                        busy_d      = 1'b0;
                        cnt_d       = 12'd0;
                        state_d     = WAIT_GAP;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else if (cnt_q < CNT_GLITCH) begin
                    frame_err_d = 1'b1;
                    busy_d      = 1'b0;
                    cnt_d       = 12'd0;
                    state_d     = WAIT_GAP;
                end else begin
                    shift_d   = {shift_q[22:0], (cnt_q >= CNT_THRESH)};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    cnt_d     = 12'd1;
                    state_d   = LOW;
                end
            end

            LOW: begin
                // a full word was shifted in on the previous falling edge
                if (bit_cnt_q == BITS_PIX) begin
                    bit_cnt_d = 5'd0;
                    if (pix_cnt_q < PIX_MAX) begin
                        grb_d         = shift_q;
                        addr_d        = pix_cnt_q;
                        pixel_valid_d = 1'b1;
                        pix_cnt_d     = pix_cnt_q + 6'd1;
                    end else begin
                        pix_cnt_d = pix_cnt_q;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end

                if (s_din) begin
                    cnt_d   = 12'd1;
                    state_d = HIGH;
                end else if (cnt_inc_s == CNT_RESET) begin
                    frame_done_d  = 1'b1;
                    pixel_count_d = pix_cnt_q;
                    // leftover bits mean the last pixel was truncated
                    frame_err_d   = (bit_cnt_q != 5'd0);
                    bit_cnt_d     = 5'd0;
                    busy_d        = 1'b0;
                    cnt_d         = 12'd0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end

            default: begin
                busy_d  = 1'b0;
                cnt_d   = 12'd0;
                state_d = WAIT_GAP;
            end
        endcase
    end

    // Main state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_GAP;
            cnt_q         <= 12'd0;
            bit_cnt_q     <= 5'd0;
            pix_cnt_q     <= 6'd0;
            shift_q       <= 24'd0;
            grb_q         <= 24'd0;
            addr_q        <= 6'd0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            pixel_count_q <= 6'd0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            shift_q       <= shift_d;
            grb_q         <= grb_d;
            addr_q        <= addr_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            pixel_count_q <= pixel_count_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

`ifdef RX_FORWARD_EN
    logic dout_q, dout_d;

    // Forward the line once this board's pixels are all taken; never while resyncing.
    always_comb begin
        dout_d = 1'b0;
        if (((state_q == HIGH) || (state_q == LOW)) && (pix_cnt_q >= PIX_MAX)) begin
            dout_d = s_din;
        end else begin
            dout_d = 1'b0;
        end
    end

    // Forwarding output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign rx.dout = dout_q;
`else
    assign rx.dout = 1'b0;
`endif

    assign rx.grb         = grb_q;
    assign rx.addr        = addr_q;
    assign rx.pixel_valid = pixel_valid_q;
    assign rx.frame_done  = frame_done_q;
    assign rx.pixel_count = pixel_count_q;
    assign rx.frame_err   = frame_err_q;
    assign rx.busy        = busy_q;

endmodule
